bus_dec: RTL and testbench

Parametrised bus address decoder, read-data/ack multiplexer and bus-error watchdog between the cpu bus master and NSLV slaves. Each slave has a base/mask window in a parameter table, with lowest index winning on overlap. It adds behaviour the fixed decoder lacks: unmapped-address and ack-timeout detection. On either error it synthesizes an ack with an error flag, captures the failing access, and raises an error interrupt until software clears it.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_dec_match.sv | 15 +
 rtl/bus_dec.sv | 152 +++++++++++++++
 tb/tb_bus_dec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the cpu bus decoder: bus widths, FSM state codes,
// error kind codes and the saturating error-count helper.
package bus_pkg;

    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int ECNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERRACK = 2'd2
    } state_t;

    typedef enum logic {
        EK_UNMAPPED = 1'b0,
        EK_TIMEOUT  = 1'b1
    } err_kind_t;

    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (v == {ECNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bus_dec_match.sv
// Single-slave address window comparator: a set mask bit means that address
// bit must equal the corresponding base bit.
module bus_dec_match
    import bus_pkg::*;
#(
    parameter logic [AW-1:0] BASE = '0,
    parameter logic [AW-1:0] MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic          hit
);

    assign hit = ((addr ^ BASE) & MASK) == '0;

endmodule

// File: rtl/bus_dec.sv
// Bus address decoder with read-data/ack mux and a bus-error watchdog that
// synthesizes error acks for unmapped or unanswered accesses.
module bus_dec
    import bus_pkg::*;
#(
    parameter int                  NSLV       = 8,
    parameter logic [30*NSLV-1:0]  SLV_BASE   = {NSLV{30'h0}},
    parameter logic [30*NSLV-1:0]  SLV_MASK   = {NSLV{30'h0}},
    parameter int                  TMO_CYCLES = 255,
    parameter int                  TMO_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_stb,
    input  logic                 m_we,
    input  logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_din,
    output logic                 m_ack,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_stb,
    input  logic [DW*NSLV-1:0]   s_dout,
    input  logic [NSLV-1:0]      s_ack,
    output logic                 err_irq,
    input  logic                 err_clr,
    output logic [AW-1:0]        err_addr,
    output logic                 err_we,
    output logic                 err_kind,
    output logic [ECNT_W-1:0]    err_cnt
);

    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] first;
    logic [NSLV:0]   below;

    assign below[0] = 1'b0;

    // first[] is the priority-resolved one-hot select: lowest hitting index wins.
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
            bus_dec_match #(
                .BASE(SLV_BASE[30*gi +: 30]),
                .MASK(SLV_MASK[30*gi +: 30])
            ) u_match (
                .addr(m_addr),
                .hit (hit[gi])
            );
            assign first[gi]   = hit[gi] & ~below[gi];
            assign below[gi+1] = below[gi] | hit[gi];
        end
    endgenerate

    logic          any_hit;
    logic          sel_ack;
    logic [DW-1:0] din_sel;

    assign any_hit = below[NSLV];
    assign sel_ack = |(first & s_ack);

    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            din_sel = din_sel | (s_dout[DW*i +: DW] & {DW{first[i]}});
        end
    end

    state_t            state_reg;
    logic [TMO_W-1:0]  cnt_reg;
    logic              err_irq_reg;
    logic [ECNT_W-1:0] err_cnt_reg;
    logic [AW-1:0]     err_addr_reg;
    logic              err_we_reg;
    err_kind_t         err_kind_reg;

    // IDLE leaves combinationally on m_stb, so the strobe-rise cycle already
    // behaves as ACTIVE. Holding rst_n low also forces the slave side quiet.
    logic busy;
    logic errack;
    logic tmo_hit;
    logic err_enter;

    assign busy      = rst_n & m_stb & ((state_reg == IDLE) | (state_reg == ACTIVE));
    assign errack    = (state_reg == ERRACK);
    assign tmo_hit   = (cnt_reg == TMO_W'(TMO_CYCLES - 1));
    assign err_enter = busy & (~any_hit | (~sel_ack & tmo_hit));

    assign s_stb = busy ? first : '0;
    assign m_ack = errack | (busy & any_hit & sel_ack);
    assign m_err = errack;
    assign m_din = (busy & any_hit) ? din_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            err_irq_reg  <= 1'b0;
            err_cnt_reg  <= '0;
            err_addr_reg <= '0;
            err_we_reg   <= 1'b0;
            err_kind_reg <= EK_UNMAPPED;
        end else begin
            case (state_reg)
                IDLE, ACTIVE: begin
                    if (!m_stb) begin
                        // Strobe withdrawn without ack: abandon quietly.
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (!any_hit) begin
                        state_reg <= ERRACK;
                        cnt_reg   <= '0;
                    end else if (sel_ack) begin
                        state_reg <= ACTIVE;
                        cnt_reg   <= '0;
                    end else if (tmo_hit) begin
                        state_reg <= ERRACK;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= ACTIVE;
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                ERRACK: begin
                    state_reg <= m_stb ? ACTIVE : IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase

            // A new error takes precedence over a simultaneous clear, but the
            // count restarts from zero when both happen together.
            if (err_enter) begin
                err_addr_reg <= m_addr;
                err_we_reg   <= m_we;
                err_kind_reg <= any_hit ? EK_TIMEOUT : EK_UNMAPPED;
                err_irq_reg  <= 1'b1;
                err_cnt_reg  <= sat_inc(err_clr ? '0 : err_cnt_reg);
            end else if (err_clr) begin
                err_irq_reg  <= 1'b0;
                err_cnt_reg  <= '0;
            end
        end
    end

    assign err_irq  = err_irq_reg;
    assign err_cnt  = err_cnt_reg;
    assign err_addr = err_addr_reg;
    assign err_we   = err_we_reg;
    assign err_kind = err_kind_reg;

endmodule

// File: tb/tb_bus_dec.sv
// Self-checking bench for bus_dec: slave latency models, scoreboard of
// expected acks, error capture, clear, saturation and mid-access reset.
module tb_bus_dec;

    localparam int NSLV = 4;
    localparam int TMO  = 8;
    localparam logic [30*NSLV-1:0] BASE = {30'h00000000, 30'h0C000000, 30'h08000000, 30'h00000000};
    localparam logic [30*NSLV-1:0] MASK = {30'h38000000, 30'h3FFFFC00, 30'h3C000000, 30'h38000000};

    logic               clk;
    logic               rst_n;
    logic               m_stb;
    logic               m_we;
    logic [29:0]        m_addr;
    logic [31:0]        m_din;
    logic               m_ack;
    logic               m_err;
    logic [NSLV-1:0]    s_stb;
    logic [32*NSLV-1:0] s_dout;
    logic [NSLV-1:0]    s_ack;
    logic               err_irq;
    logic               err_clr;
    logic [29:0]        err_addr;
    logic               err_we;
    logic               err_kind;
    logic [7:0]         err_cnt;

    bus_dec #(
        .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TMO_CYCLES(TMO), .TMO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_din(m_din), .m_ack(m_ack), .m_err(m_err), .s_stb(s_stb), .s_dout(s_dout),
        .s_ack(s_ack), .err_irq(err_irq), .err_clr(err_clr), .err_addr(err_addr),
        .err_we(err_we), .err_kind(err_kind), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: slave i acks once its strobe has been high lat[i] cycles.
    int          lat   [NSLV] = '{0, 2, 1000, 0};
    logic [31:0] sdata [NSLV] = '{32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
    int          scnt  [NSLV] = '{0, 0, 0, 0};

    always_comb begin
        s_ack  = '0;
        s_dout = '0;
        for (int i = 0; i < NSLV; i++) begin
            s_ack[i]            = s_stb[i] && (scnt[i] == lat[i]);
            s_dout[32*i +: 32]  = sdata[i];
        end
    end

    always @(posedge clk) begin
        for (int j = 0; j < NSLV; j++)
            scnt[j] <= (s_stb[j] && !s_ack[j]) ? scnt[j] + 1 : 0;
    end

    typedef struct {
        logic        err;
        logic [31:0] din;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one access, compare the ack against the scoreboard head.
    // clr_at: cycle (relative to strobe rise) in which err_clr is pulsed, -1 for none.
    task automatic access(input logic [29:0] addr, input logic we, input logic [3:0] exp_stb,
                          input logic exp_err, input logic [31:0] exp_din, input int exp_lat,
                          input int clr_at);
        exp_t e;
        exp_t p;
        bit   acked;
        e.err = exp_err;
        e.din = exp_din;
        e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        m_stb   = 1'b1;
        m_addr  = addr;
        m_we    = we;
        err_clr = (clr_at == 0);
        acked   = 1'b0;
        for (int k = 0; k < 20 && !acked; k++) begin
            #1;
            chk("s_stb", 32'(s_stb), 32'((exp_err && k == exp_lat) ? 4'b0000 : exp_stb));
            if (m_ack) begin
                p = sb.pop_front();
                chk("m_err", 32'(m_err), 32'(p.err));
                chk("m_din", m_din, p.din);
                chk("ack_lat", 32'(k), 32'(p.lat));
                $display("[TB] access addr=%h we=%b ack_cycle=%0d err=%b din=%h irq=%b cnt=%0d",
                         addr, we, k, m_err, m_din, err_irq, err_cnt);
                acked = 1'b1;
            end
            @(negedge clk);
            err_clr = (k + 1 == clr_at);
        end
        if (!acked) begin
            chk("ack_timeout", 32'(0), 32'(1));
            sb.delete();
        end
        m_stb   = 1'b0;
        m_we    = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("idle_ack", 32'(m_ack), 32'(0));
        @(negedge clk);
    endtask

    task automatic chk_err(input logic irq, input logic [7:0] cnt, input logic kind,
                           input logic [29:0] addr, input logic we);
        chk("err_irq", 32'(err_irq), 32'(irq));
        chk("err_cnt", 32'(err_cnt), 32'(cnt));
        chk("err_kind", 32'(err_kind), 32'(kind));
        chk("err_addr", 32'(err_addr), 32'(addr));
        chk("err_we", 32'(err_we), 32'(we));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int acks_seen;
        rst_n   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_ack", 32'(m_ack), 32'(0));
        chk("rst_m_err", 32'(m_err), 32'(0));
        chk("rst_m_din", m_din, 32'(0));
        chk("rst_s_stb", 32'(s_stb), 32'(0));
        chk_err(1'b0, 8'd0, 1'b0, 30'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Slave 1 read, ack in cycle 2
        access(30'h08000004, 1'b0, 4'b0010, 1'b0, 32'hDEADBEEF, 2, -1);
        chk("irq_after_read", 32'(err_irq), 32'(0));

        // Unmapped write
        access(30'h3FFFFFFF, 1'b1, 4'b0000, 1'b1, 32'h0, 1, -1);
        chk_err(1'b1, 8'd1, 1'b0, 30'h3FFFFFFF, 1'b1);

        // Slave 2 never acks: timeout
        access(30'h0C000010, 1'b0, 4'b0100, 1'b1, 32'h0, TMO, -1);
        chk_err(1'b1, 8'd2, 1'b1, 30'h0C000010, 1'b0);

        // Overlap of slaves 0 and 3: slave 0 wins
        access(30'h00000100, 1'b0, 4'b0001, 1'b0, 32'h11111111, 0, -1);

        // Clear in the same cycle as a new timeout's error entry
        access(30'h0C000020, 1'b1, 4'b0100, 1'b1, 32'h0, TMO, TMO - 1);
        chk_err(1'b1, 8'd1, 1'b1, 30'h0C000020, 1'b1);

        // Isolated clear
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("clr_irq", 32'(err_irq), 32'(0));
        chk("clr_cnt", 32'(err_cnt), 32'(0));

        // Saturation
        for (int n = 0; n < 260; n++)
            access(30'h3FFFFFFF, 1'b0, 4'b0000, 1'b1, 32'h0, 1, -1);
        chk("sat_cnt", 32'(err_cnt), 32'(255));
        chk("sat_irq", 32'(err_irq), 32'(1));

        // Reset in cycle 4 of a timing-out access
        @(negedge clk);
        m_stb  = 1'b1;
        m_addr = 30'h0C000010;
        m_we   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_m_ack", 32'(m_ack), 32'(0));
        chk("mrst_m_err", 32'(m_err), 32'(0));
        chk("mrst_m_din", m_din, 32'(0));
        chk("mrst_s_stb", 32'(s_stb), 32'(0));
        chk_err(1'b0, 8'd0, 1'b0, 30'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_stb = 1'b0;
        m_we  = 1'b0;
        acks_seen = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_ack) acks_seen++;
            @(negedge clk);
        end
        chk("mrst_no_ack", 32'(acks_seen), 32'(0));
        access(30'h08000004, 1'b0, 4'b0010, 1'b0, 32'hDEADBEEF, 2, -1);
        chk("mrst_irq", 32'(err_irq), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
